// File: rtl/regbank_arbiter.sv
// regbank_arbiter
// Shares one single-port register bank (NREGS words of WIDTH bits) between
// NREQ requesters. Each grant performs one read-modify-write access: the
// pre-write word is returned on rdata and, for write requests, the new word
// is committed at the same edge. Priority is round-robin by default.
//
// Build option: define REGARB_FIXED_PRIO_EN to switch to fixed priority
// (lowest requesting index always wins). Timing, reset and ACK behaviour
// are identical in both builds.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   req        per-requester request, held until its grant is seen
//   req_we     per-requester write enable (1 = write, 0 = read only)
//   req_addr   flattened addresses, requester i at [i*AW +: AW]
//   req_wdata  flattened write data, requester i at [i*WIDTH +: WIDTH]
//   gnt        one-hot grant, high for exactly one cycle
//   rdata      pre-write word at the granted address (0 if out of range)
//   busy       high while the FSM sits in ACK
//   last_gnt   index of the most recently granted requester
module regbank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int NREGS = 8,
  parameter int AW    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      rdata,
  output logic                  busy,
  output logic [2:0]            last_gnt
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

  state_t            state_q;
  logic [NREQ-1:0]   gnt_q;
  logic [WIDTH-1:0]  rdata_q;
  logic              busy_q;
  logic [2:0]        lastGnt_q;
  logic [WIDTH-1:0]  bank_q [NREGS];

  logic [2:0]        winner_d;
  logic [NREQ-1:0]   gnt_d;
  logic [WIDTH-1:0]  rdata_d;
  logic [AW-1:0]     winAddr;
  logic [WIDTH-1:0]  winData;
  logic              winWe;
  logic              inRange;
  logic [IW-1:0]     bankIdx;

  // Winner selection. The round-robin scan is split into two passes so no
  // modulo index is needed: first the indices above the last winner, then
  // wrap around to the indices up to and including it.
  function automatic logic [2:0] pickWinner(input logic [NREQ-1:0] r,
                                            input logic [2:0] last);
    logic [2:0] w;
    logic       found;
    w     = '0;
    found = 1'b0;
`ifdef REGARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) begin
      if (!found && r[i]) begin
        w     = 3'(i);
        found = 1'b1;
      end
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      if (!found && (i > int'(last)) && r[i]) begin
        w     = 3'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && (i <= int'(last)) && r[i]) begin
        w     = 3'(i);
        found = 1'b1;
      end
    end
`endif
    return w;
  endfunction

  // Combinational view of what the next IDLE edge would do: pick the
  // winner, route its address/data/write-enable, and look up the current
  // bank word. Only the winner's fields ever reach the bank.
  always_comb begin
    winner_d = pickWinner(req, lastGnt_q);
    winAddr  = req_addr[int'(winner_d)*AW +: AW];
    winData  = req_wdata[int'(winner_d)*WIDTH +: WIDTH];
    winWe    = req_we[int'(winner_d) +: 1];
    inRange  = (int'(winAddr) < NREGS);
    bankIdx  = winAddr[IW-1:0];
    gnt_d    = NREQ'(1) << winner_d;
    rdata_d  = inRange ? bank_q[bankIdx] : '0;
  end

  // Two-state FSM with registered outputs. IDLE grants at most one
  // requester per edge and commits its access; ACK is a mandatory one-cycle
  // gap during which requests are ignored. rdata is only updated on a grant
  // so it holds the last returned word while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      lastGnt_q <= 3'(NREQ - 1);
      for (int i = 0; i < NREGS; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_q     <= gnt_d;
            rdata_q   <= rdata_d;
            lastGnt_q <= winner_d;
            busy_q    <= 1'b1;
            state_q   <= ACK;
            if (winWe && inRange) begin
              bank_q[bankIdx] <= winData;
            end
          end
        end
        ACK: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign last_gnt = lastGnt_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
// tb_regbank_arbiter
// Self-checking bench for regbank_arbiter (default parameters). Expected
// grants are pushed to a scoreboard queue when stimulus is driven and popped
// when the DUT raises gnt. A reference copy of the bank tracks committed
// writes. Handles both the round-robin and REGARB_FIXED_PRIO_EN builds.
module tb_regbank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int NREGS = 8;
  localparam int AW    = 4;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      rdata;
  logic                  busy;
  logic [2:0]            last_gnt;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] rdata;
    logic [2:0]       last;
  } expect_t;

  typedef struct {
    int               idx;
    logic             we;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] expRdata;
  } vector_t;

  expect_t          sbQ [$];
  vector_t          vecs [12];
  logic [WIDTH-1:0] mdl [NREGS];

  regbank_arbiter #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .NREGS(NREGS),
    .AW   (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .gnt      (gnt),
    .rdata    (rdata),
    .busy     (busy),
    .last_gnt (last_gnt)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] expRd(input logic [AW-1:0] a);
    return (int'(a) < NREGS) ? mdl[a[2:0]] : '0;
  endfunction

  task automatic pushExpect(input int idx, input logic [WIDTH-1:0] rd);
    expect_t e;
    e.gnt   = 4'(1 << idx);
    e.rdata = rd;
    e.last  = 3'(idx);
    sbQ.push_back(e);
  endtask

  // Compare the grant currently on the outputs with the oldest expectation.
  task automatic popCheck(input string name);
    expect_t e;
    if (sbQ.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: got unexpected grant 0x%0h, expected none", name, gnt);
    end else begin
      e = sbQ.pop_front();
      checkOutput($sformatf("%s gnt", name), 32'(gnt), 32'(e.gnt));
      checkOutput($sformatf("%s rdata", name), 32'(rdata), 32'(e.rdata));
      checkOutput($sformatf("%s last_gnt", name), 32'(last_gnt), 32'(e.last));
      checkOutput($sformatf("%s busy", name), 32'(busy), 32'd1);
    end
  endtask

  // Wait (bounded) for gnt at negedges; lat is the number of negedges
  // skipped before gnt appeared, or -1 on timeout.
  task automatic waitGrant(input string name, output int lat);
    lat = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (gnt != '0) begin
        lat = n;
        return;
      end
    end
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s timeout: got no grant in 10 cycles, expected a grant", name);
  endtask

  // Drive a single request; other requesters idle but carry write-enabled
  // junk that must never reach the bank.
  task automatic applyStimulus(input int idx, input logic we,
                               input logic [AW-1:0] addr,
                               input logic [WIDTH-1:0] wdata);
    req_we = '1;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW]       = 4'(i + 5);
      req_wdata[i*WIDTH +: WIDTH] = 8'($urandom);
    end
    req_we[idx]                   = we;
    req_addr[idx*AW +: AW]        = addr;
    req_wdata[idx*WIDTH +: WIDTH] = wdata;
    req      = '0;
    req[idx] = 1'b1;
  endtask

  // One complete request/grant handshake. Inputs change 1 ns after an edge;
  // the first negedge comes before the sampling edge, so gnt is expected at
  // the second negedge (lat == 1).
  task automatic singleTxn(input int idx, input logic we,
                           input logic [AW-1:0] addr,
                           input logic [WIDTH-1:0] wdata,
                           input logic [WIDTH-1:0] expRdata,
                           input string name);
    int lat;
    @(posedge clk);
    #1;
    applyStimulus(idx, we, addr, wdata);
    pushExpect(idx, expRdata);
    waitGrant(name, lat);
    if (lat >= 0) begin
      checkOutput($sformatf("%s latency", name), 32'(lat), 32'd1);
      popCheck(name);
    end else begin
      sbQ.delete();
    end
    @(posedge clk);
    #1;
    req = '0;
    if (we && (int'(addr) < NREGS)) mdl[addr[2:0]] = wdata;
  endtask

  initial begin
    int lat;
    int first;
    int second;
    int idx;
    int grants;
    logic [AW-1:0] rrAddr [NREQ];

    vecs[0]  = '{1, 1'b1, 4'd3,  8'hA5, 8'h00};
    vecs[1]  = '{1, 1'b0, 4'd3,  8'h00, 8'hA5};
    vecs[2]  = '{2, 1'b1, 4'd0,  8'h3C, 8'h00};
    vecs[3]  = '{0, 1'b0, 4'd0,  8'h00, 8'h3C};
    vecs[4]  = '{3, 1'b1, 4'd7,  8'h5A, 8'h00};
    vecs[5]  = '{3, 1'b1, 4'd7,  8'h11, 8'h5A};
    vecs[6]  = '{0, 1'b0, 4'd7,  8'h00, 8'h11};
    vecs[7]  = '{2, 1'b1, 4'd9,  8'hFF, 8'h00};
    vecs[8]  = '{2, 1'b0, 4'd9,  8'h00, 8'h00};
    vecs[9]  = '{1, 1'b1, 4'd15, 8'hEE, 8'h00};
    vecs[10] = '{0, 1'b1, 4'd3,  8'h77, 8'hA5};
    vecs[11] = '{1, 1'b0, 4'd3,  8'h00, 8'h77};

    rrAddr[0] = 4'd7;
    rrAddr[1] = 4'd3;
    rrAddr[2] = 4'd0;
    rrAddr[3] = 4'd9;

    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
    rst_n     = 1'b0;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;

    // Power-on reset values.
    repeat (3) @(negedge clk);
    checkOutput("reset gnt", 32'(gnt), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset last_gnt", 32'(last_gnt), 32'd3);
    checkOutput("reset rdata", 32'(rdata), 32'd0);
    rst_n = 1'b1;

    // Table of single-requester accesses, including out-of-range addresses.
    for (int v = 0; v < 12; v++) begin
      singleTxn(vecs[v].idx, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                vecs[v].expRdata, $sformatf("vec%0d", v));
    end

    // rdata holds while idle.
    @(negedge clk);
    checkOutput("idle gnt", 32'(gnt), 32'd0);
    checkOutput("idle busy", 32'(busy), 32'd0);
    checkOutput("idle rdata hold", 32'(rdata), 32'h77);

    // Whole-bank readback: out-of-range and non-winner junk left no trace.
    for (int a = 0; a < NREGS; a++) begin
      singleTxn(0, 1'b0, 4'(a), 8'h00, mdl[a], $sformatf("readback%0d", a));
    end

    // Simultaneous requests 0 and 2 with last_gnt = 0.
    singleTxn(0, 1'b0, 4'd0, 8'h00, mdl[0], "simul setup");
`ifdef REGARB_FIXED_PRIO_EN
    first  = 0;
    second = 2;
`else
    first  = 2;
    second = 0;
`endif
    @(posedge clk);
    #1;
    req_we                 = '0;
    req_addr[0*AW +: AW]   = 4'd3;
    req_addr[2*AW +: AW]   = 4'd7;
    req                    = 4'b0101;
    pushExpect(first,  expRd(req_addr[first*AW +: AW]));
    pushExpect(second, expRd(req_addr[second*AW +: AW]));
    waitGrant("simul first", lat);
    if (lat >= 0) popCheck("simul first");
    @(posedge clk);
    #1;
    req[first] = 1'b0;
    waitGrant("simul second", lat);
    if (lat >= 0) popCheck("simul second");
    @(posedge clk);
    #1;
    req = '0;
    sbQ.delete();

    // All four requesting continuously, starting from last_gnt = 3.
    singleTxn(3, 1'b0, 4'd0, 8'h00, mdl[0], "rr setup");
    @(posedge clk);
    #1;
    req_we = '0;
    for (int i = 0; i < NREQ; i++) req_addr[i*AW +: AW] = rrAddr[i];
    for (int g = 0; g < 8; g++) begin
`ifdef REGARB_FIXED_PRIO_EN
      idx = 0;
`else
      idx = g % NREQ;
`endif
      pushExpect(idx, expRd(rrAddr[idx]));
    end
    req = '1;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      checkOutput($sformatf("rr cadence %0d", n), 32'(gnt != '0), 32'(n % 2));
      checkOutput($sformatf("rr busy %0d", n), 32'(busy), 32'(n % 2));
      if (gnt != '0) popCheck($sformatf("rr grant %0d", n / 2));
    end
    @(posedge clk);
    #1;
    req = '0;
    checkOutput("rr scoreboard drained", 32'(sbQ.size()), 32'd0);
    sbQ.delete();

    // Stale request: held one extra cycle gives two grants; a clean pulse
    // gives exactly one.
    for (int pass = 0; pass < 2; pass++) begin
      grants = 0;
      @(posedge clk);
      #1;
      applyStimulus(1, 1'b0, 4'd3, 8'h00);
      for (int cyc = 0; cyc < 10; cyc++) begin
        @(negedge clk);
        if (gnt != '0) grants++;
        @(posedge clk);
        #1;
        if (cyc == ((pass == 0) ? 3 : 1)) req = '0;
      end
      checkOutput((pass == 0) ? "stale held grants" : "single pulse grants",
                  32'(grants), (pass == 0) ? 32'd2 : 32'd1);
    end

    // Reset asserted while in ACK: outputs clear immediately, bank clears.
    singleTxn(0, 1'b1, 4'd5, 8'h99, mdl[5], "pre-reset write");
    @(posedge clk);
    #1;
    applyStimulus(2, 1'b1, 4'd6, 8'h42);
    pushExpect(2, mdl[6]);
    waitGrant("reset txn", lat);
    if (lat >= 0) popCheck("reset txn");
    sbQ.delete();
    rst_n = 1'b0;
    req   = '0;
    #1;
    checkOutput("midack reset gnt", 32'(gnt), 32'd0);
    checkOutput("midack reset busy", 32'(busy), 32'd0);
    checkOutput("midack reset last_gnt", 32'(last_gnt), 32'd3);
    checkOutput("midack reset rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
    for (int a = 0; a < NREGS; a++) begin
      singleTxn(0, 1'b0, 4'(a), 8'h00, 8'h00, $sformatf("post-reset read%0d", a));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
